// File: rtl/enc_layer_sched.sv
// enc_layer_sched: time-multiplexed dense-layer controller.
// Computes y[r] = b[r] + sum_i x[i]*w[r][i] for N_OUT neurons using one
// shared fixed-point multiplier and one shared adder, one MAC per cycle.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   start    : run request, sampled in IDLE only
//   abort    : synchronous run cancel (ignored in IDLE)
//   x        : input vector, element i at [i*BITSIZE +: BITSIZE], captured at start
//   w        : weights, w[r][i] at [(r*N_IN+i)*BITSIZE +: BITSIZE], stable while busy
//   b        : biases, b[r] at [r*BITSIZE +: BITSIZE], stable while busy
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse when a run completes
//   y        : results, y[r] at [r*BITSIZE +: BITSIZE]
//   y_valid  : bit r sticky-set when y[r] is written
//
// Build option: define ENC_SAT_EN to make mul/add saturate instead of wrap.
// Cycle timing is identical in both builds.
module enc_layer_sched #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic                          busy,
  output logic                          done,
  output logic [BITSIZE*N_OUT-1:0]      y,
  output logic [N_OUT-1:0]              y_valid
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int RW = $clog2(N_OUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N_OUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

`ifdef ENC_SAT_EN
  localparam logic signed [2*BITSIZE-1:0] PMAX = {{(BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [2*BITSIZE-1:0] PMIN = {{(BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
  localparam logic signed [BITSIZE-1:0]   WMAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0]   WMIN = {1'b1, {(BITSIZE-1){1'b0}}};
`endif

  // Fixed-point multiply: full-width signed product, arithmetic shift right
  // by FRAC (floor), then wrap or clamp to BITSIZE bits.
  function automatic logic signed [BITSIZE-1:0] fx_mul(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] c
  );
    logic signed [2*BITSIZE-1:0] prod;
    prod = a * c;
    prod = prod >>> FRAC;
`ifdef ENC_SAT_EN
    if (prod > PMAX)      return WMAX;
    else if (prod < PMIN) return WMIN;
    else                  return BITSIZE'(prod);
`else
    return BITSIZE'(prod);
`endif
  endfunction

  // Two's-complement add, wrap or clamp on overflow.
  function automatic logic signed [BITSIZE-1:0] fx_add(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] c
  );
`ifdef ENC_SAT_EN
    logic signed [BITSIZE:0] sum;
    sum = {a[BITSIZE-1], a} + {c[BITSIZE-1], c};
    // Overflow shows as disagreement between the guard bit and the sign bit.
    if (sum[BITSIZE] != sum[BITSIZE-1]) return sum[BITSIZE] ? WMIN : WMAX;
    else                                return BITSIZE'(sum);
`else
    return a + c;
`endif
  endfunction

  logic [2:0]                state;
  logic [BITSIZE*N_IN-1:0]   xcap;
  logic signed [BITSIZE-1:0] acc;
  logic [IW-1:0]             i_cnt;
  logic [RW-1:0]             r_cnt;

  logic signed [BITSIZE-1:0] x_op;
  logic signed [BITSIZE-1:0] w_op;
  logic signed [BITSIZE-1:0] b_op;

  // Operand selection for the shared multiplier; i_cnt reaches N_IN only in
  // STORE where the operands are unused, so clamp to keep the select in range.
  always_comb begin
    int unsigned ii;
    int unsigned rr;
    ii = (i_cnt <= I_LAST) ? 32'(i_cnt) : 32'd0;
    rr = (r_cnt <= R_LAST) ? 32'(r_cnt) : 32'd0;
    x_op = xcap[ii*BITSIZE +: BITSIZE];
    w_op = w[(rr*N_IN + ii)*BITSIZE +: BITSIZE];
    b_op = b[rr*BITSIZE +: BITSIZE];
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      xcap    <= '0;
      acc     <= '0;
      i_cnt   <= '0;
      r_cnt   <= '0;
      y       <= '0;
      y_valid <= '0;
    end else if (abort && state != S_IDLE) begin
      // Cancel: results already written stay in y but are no longer flagged.
      state   <= S_IDLE;
      y_valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            xcap    <= x;
            r_cnt   <= '0;
            y_valid <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc   <= b_op;
          i_cnt <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc   <= fx_add(acc, fx_mul(x_op, w_op));
          i_cnt <= i_cnt + 1'b1;
          if (i_cnt == I_LAST) state <= S_STORE;
        end
        S_STORE: begin
          y[32'(r_cnt)*BITSIZE +: BITSIZE] <= acc;
          y_valid <= y_valid | (N_OUT'(1) << r_cnt);
          if (r_cnt < R_LAST) begin
            r_cnt <= r_cnt + 1'b1;
            state <= S_LOAD;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_layer_sched.sv
module tb_enc_layer_sched;
  localparam int BS = 16;
  localparam int NI = 6;
  localparam int NO = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [BS*NI-1:0]  x;
  logic [BS*NI*NO-1:0] w;
  logic [BS*NO-1:0]  b;
  logic              busy;
  logic              done;
  logic [BS*NO-1:0]  y;
  logic [NO-1:0]     y_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enc_layer_sched #(.BITSIZE(BS), .FRAC(8), .N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .x(x), .w(w), .b(b),
    .busy(busy), .done(done), .y(y), .y_valid(y_valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  // Full run: start at edge k, x replaced by x_after right after k, optional
  // ignored start pulses at cycles rp1/rp2. Checks busy, y_valid timing, done.
  task automatic run(input string tag, input logic [BS*NI-1:0] x_after,
                     input int rp1, input int rp2);
    int done_at;
    int done_cnt;
    logic [NO-1:0] m;
    done_at  = -1;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = x_after;
    chk({tag, ":busy_k"}, 64'(busy), 64'd1);
    chk({tag, ":yv_k"}, 64'(y_valid), 64'd0);
    for (int n = 1; n <= 34; n++) begin
      if (n == rp1 || n == rp2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      if (n <= 32 && (n % 8 == 0 || n % 8 == 7)) begin
        m = NO'((1 << (n / 8)) - 1);
        chk($sformatf("%s:yv_n%0d", tag, n), 64'(y_valid), 64'(m));
      end
      if (n == 32) chk({tag, ":busy_32"}, 64'(busy), 64'd1);
      if (n == 33) chk({tag, ":busy_33"}, 64'(busy), 64'd0);
    end
    chk({tag, ":done_at"}, 64'(done_at), 64'd32);
    chk({tag, ":done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_y;
    int dcnt;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    x = '0;
    w = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:y", y, 64'd0);
    chk("rst:yv", 64'(y_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1.0 * 1.0 summed six times -> 6.0
    x = {NI{16'h0100}};
    w = {NI*NO{16'h0100}};
    b = '0;
    run("ones", x, -1, -1);
    chk("ones:y", y, rep4(16'h0600));
    chk("ones:yv", 64'(y_valid), 64'hF);

    // zero weights: result is the bias; y keeps old values until rewritten
    w = '0;
    b = {16'h7FFF, 16'h0000, 16'hFF00, 16'h0080};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bias:y_kept", y, rep4(16'h0600));
    repeat (40) @(posedge clk);
    #1;
    chk("bias:y", y, {16'h7FFF, 16'h0000, 16'hFF00, 16'h0080});
    run("bias", x, -1, -1);
    chk("bias:y2", y, {16'h7FFF, 16'h0000, 16'hFF00, 16'h0080});

    // overflow: 127.0 * 1.0 six times
    x = {NI{16'h7F00}};
    w = {NI*NO{16'h0100}};
    b = '0;
    run("ovf_pos", x, -1, -1);
`ifdef ENC_SAT_EN
    exp_y = rep4(16'h7FFF);
`else
    exp_y = rep4(16'hFA00);
`endif
    chk("ovf_pos:y", y, exp_y);

    x = {NI{16'h8000}};
    run("ovf_neg", x, -1, -1);
`ifdef ENC_SAT_EN
    exp_y = rep4(16'h8000);
`else
    exp_y = rep4(16'h0000);
`endif
    chk("ovf_neg:y", y, exp_y);

    // floor rounding: (-1/256) * 0.5 -> -1/256 each term, sum -6/256
    x = {NI{16'hFFFF}};
    w = {NI*NO{16'h0080}};
    run("floor", x, -1, -1);
    chk("floor:y", y, rep4(16'hFFFA));

    // diagonal weights with distinct inputs and biases: y[r] = x[r] + b[r]
    w = '0;
    for (int r = 0; r < NO; r++) begin
      w[(r*NI + r)*BS +: BS] = 16'h0100;
      b[r*BS +: BS] = 16'(16 * r);
    end
    for (int i = 0; i < NI; i++) x[i*BS +: BS] = 16'(256 * (i + 1));
    run("diag", x, -1, -1);
    chk("diag:y", y, {16'h0430, 16'h0320, 16'h0210, 16'h0100});

    // start while busy is ignored
    x = {NI{16'h0100}};
    w = {NI*NO{16'h0100}};
    b = '0;
    run("repulse", x, 5, 20);
    chk("repulse:y", y, rep4(16'h0600));

    // abort: start+abort together in IDLE is accepted, abort at cycle 12
    w = '0;
    b = {NO{16'h1234}};
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort:accepted", 64'(busy), 64'd1);
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); #1;
    end
    chk("abort:yv_pre", 64'(y_valid), 64'h1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort:busy", 64'(busy), 64'd0);
    chk("abort:yv", 64'(y_valid), 64'd0);
    chk("abort:y", y, {16'h0600, 16'h0600, 16'h0600, 16'h1234});
    dcnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("abort:no_done", 64'(dcnt), 64'd0);

    // asynchronous reset mid-run, between clock edges
    x = {NI{16'h0100}};
    w = {NI*NO{16'h0100}};
    b = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst:busy", 64'(busy), 64'd0);
    chk("arst:done", 64'(done), 64'd0);
    chk("arst:y", y, 64'd0);
    chk("arst:yv", 64'(y_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // x changed after start: captured values must be used
    run("xcap", {NI{16'h0200}}, -1, -1);
    chk("xcap:y", y, rep4(16'h0600));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
